alarm_zone_controller: RTL and testbench

//  Consumes the 10 ms terminal-count tick from the timer stage and sequences the alarm:

---
 rtl/alarm_zone_controller.sv | 125 ++++++++++++
 tb/tb_alarm_zone_controller.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_zone_controller.sv
// rtl/alarm_zone_controller.sv - tick-driven alarm sequencer: disarmed, exit delay, armed, entry delay, alarm
module alarm_zone_controller #(
    parameter int NZONE       = 4,
    parameter int CNT_W       = 15,
    parameter int EXIT_TICKS  = 3000,
    parameter int ENTRY_TICKS = 1500,
    parameter int SIREN_TICKS = 18000
) (
    input  logic             clock50,
    input  logic             Mr,
    input  logic             tick,
    input  logic             arm,
    input  logic             disarm,
    input  logic [NZONE-1:0] zone,
    output logic [2:0]       state,
    output logic             siren,
    output logic             armed_led,
    output logic             alarm_mem,
    output logic [CNT_W-1:0] remaining,
    output logic             tmr_clr
);

    typedef enum logic [2:0] {
        S_DISARMED  = 3'd0,
        S_EXIT_DLY  = 3'd1,
        S_ARMED     = 3'd2,
        S_ENTRY_DLY = 3'd3,
        S_ALARM     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_TICKS);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic             tick_q;
    logic             tick_evt;
    logic             timed_q;
    logic             step_down;
    logic             expire;
    logic             inst_trip;
    logic             entering;
    logic [CNT_W-1:0] rem_d;
    logic             mem_d;
    logic             clr_d;

    assign tick_evt  = tick & ~tick_q;
    assign inst_trip = |zone[NZONE-1:1];
    assign timed_q   = (state_q == S_EXIT_DLY) || (state_q == S_ENTRY_DLY) || (state_q == S_ALARM);
    // tmr_clr marks the first cycle of a timed state, where a tick edge must not count
    assign step_down = timed_q && tick_evt && !tmr_clr && (remaining != '0);
    assign expire    = step_down && (remaining == ONE);
    assign state     = state_q;

    always_comb begin
        state_d = state_q;
        mem_d   = alarm_mem;
        if (disarm) begin
            state_d = S_DISARMED;
            mem_d   = 1'b0;
        end else begin
            case (state_q)
                S_DISARMED:  if (arm) state_d = S_EXIT_DLY;
                S_EXIT_DLY: begin
                    if (inst_trip)   state_d = S_ALARM;
                    else if (expire) state_d = zone[0] ? S_ENTRY_DLY : S_ARMED;
                end
                S_ARMED: begin
                    if (inst_trip)    state_d = S_ALARM;
                    else if (zone[0]) state_d = S_ENTRY_DLY;
                end
                S_ENTRY_DLY: if (inst_trip || expire) state_d = S_ALARM;
                S_ALARM:     if (expire) state_d = S_ARMED;
                default:     state_d = S_DISARMED;
            endcase
        end

        entering = (state_d != state_q);
        if (entering && state_d == S_ALARM) mem_d = 1'b1;

        clr_d = 1'b0;
        rem_d = '0;
        case (state_d)
            S_EXIT_DLY: begin
                clr_d = entering;
                rem_d = entering ? EXIT_LD : (step_down ? remaining - ONE : remaining);
            end
            S_ENTRY_DLY: begin
                clr_d = entering;
                rem_d = entering ? ENTRY_LD : (step_down ? remaining - ONE : remaining);
            end
            S_ALARM: begin
                clr_d = entering;
                rem_d = entering ? SIREN_LD : (step_down ? remaining - ONE : remaining);
            end
            default: begin
                clr_d = 1'b0;
                rem_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock50) begin
        if (!Mr) begin
            state_q   <= S_DISARMED;
            tick_q    <= 1'b0;
            siren     <= 1'b0;
            armed_led <= 1'b0;
            alarm_mem <= 1'b0;
            remaining <= '0;
            tmr_clr   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick;
            siren     <= (state_d == S_ALARM);
            armed_led <= (state_d != S_DISARMED);
            alarm_mem <= mem_d;
            remaining <= rem_d;
            tmr_clr   <= clr_d;
        end
    end

endmodule

// File: tb/tb_alarm_zone_controller.sv
// tb/tb_alarm_zone_controller.sv - directed and randomized checks of alarm_zone_controller
module tb_alarm_zone_controller;

    localparam int EXIT_T  = 3;
    localparam int ENTRY_T = 2;
    localparam int SIREN_T = 4;

    logic        clock50;
    logic        Mr;
    logic        tick;
    logic        arm;
    logic        disarm;
    logic [3:0]  zone;
    logic [2:0]  state;
    logic        siren;
    logic        armed_led;
    logic        alarm_mem;
    logic [14:0] remaining;
    logic        tmr_clr;

    int tests = 0;
    int fails = 0;

    int m_state = 0;
    int m_rem   = 0;
    int m_mem   = 0;
    int m_clr   = 0;
    int m_tq    = 0;

    alarm_zone_controller #(
        .NZONE(4), .CNT_W(15),
        .EXIT_TICKS(EXIT_T), .ENTRY_TICKS(ENTRY_T), .SIREN_TICKS(SIREN_T)
    ) dut (
        .clock50(clock50), .Mr(Mr), .tick(tick), .arm(arm), .disarm(disarm),
        .zone(zone), .state(state), .siren(siren), .armed_led(armed_led),
        .alarm_mem(alarm_mem), .remaining(remaining), .tmr_clr(tmr_clr)
    );

    initial clock50 = 1'b0;
    always #5 clock50 = ~clock50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of the alarm rules, in plain integer terms
    task automatic model_edge();
        bit evt;
        bit trip;
        bit dec;
        bit done;
        int nxt;
        evt = tick && (m_tq == 0);
        if (!Mr) begin
            m_state = 0; m_rem = 0; m_mem = 0; m_clr = 0; m_tq = 0;
            return;
        end
        m_tq = int'(tick);
        dec  = 0;
        done = 0;
        if ((m_state == 1 || m_state == 3 || m_state == 4) && evt && m_clr == 0 && m_rem > 0) begin
            if (m_rem == 1) done = 1;
            else            dec  = 1;
        end
        trip = |zone[3:1];
        nxt  = m_state;
        if (disarm) begin
            nxt   = 0;
            m_mem = 0;
        end else if (m_state == 0) begin
            if (arm) nxt = 1;
        end else if (m_state == 4) begin
            if (done) nxt = 2;
        end else if (trip) begin
            nxt = 4;
        end else if (m_state == 1) begin
            if (done) nxt = zone[0] ? 3 : 2;
        end else if (m_state == 2) begin
            if (zone[0]) nxt = 3;
        end else if (done) begin
            nxt = 4;
        end
        if (nxt != m_state) begin
            m_clr = (nxt == 1 || nxt == 3 || nxt == 4) ? 1 : 0;
            m_rem = (nxt == 1) ? EXIT_T : (nxt == 3) ? ENTRY_T : (nxt == 4) ? SIREN_T : 0;
            if (nxt == 4) m_mem = 1;
        end else begin
            m_clr = 0;
            if (dec) m_rem = m_rem - 1;
        end
        m_state = nxt;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock50);
            model_edge();
            @(negedge clock50);
            check("model_state", 32'(state), 32'(m_state));
            check("model_remaining", 32'(remaining), 32'(m_rem));
            check("model_alarm_mem", 32'(alarm_mem), 32'(m_mem));
            check("model_tmr_clr", 32'(tmr_clr), 32'(m_clr));
            check("model_siren", 32'(siren), (m_state == 4) ? 32'd1 : 32'd0);
            check("model_armed_led", 32'(armed_led), (m_state != 0) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic tick_pulse();
        tick = 1'b0;
        step(7);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    initial begin
        Mr = 1'b0; tick = 1'b0; arm = 1'b0; disarm = 1'b0; zone = 4'b0000;

        step(2);
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs", {26'd0, siren, armed_led, alarm_mem, tmr_clr, 2'b00}, 32'd0);
        check("reset_remaining", 32'(remaining), 32'd0);
        Mr = 1'b1;
        step(1);

        arm = 1'b1;
        step(1);
        check("exit_state", 32'(state), 32'd1);
        check("exit_rem3", 32'(remaining), 32'd3);
        check("exit_clr", 32'(tmr_clr), 32'd1);
        arm = 1'b0;
        step(1);
        check("exit_clr_once", 32'(tmr_clr), 32'd0);
        tick_pulse();
        check("exit_rem2", 32'(remaining), 32'd2);
        tick_pulse();
        check("exit_rem1", 32'(remaining), 32'd1);
        tick_pulse();
        check("armed_state", 32'(state), 32'd2);
        check("armed_rem0", 32'(remaining), 32'd0);

        zone = 4'b0001;
        step(1);
        check("entry_state", 32'(state), 32'd3);
        check("entry_rem", 32'(remaining), 32'd2);
        zone = 4'b0000;
        tick_pulse();
        tick_pulse();
        check("alarm_state", 32'(state), 32'd4);
        check("alarm_siren", 32'(siren), 32'd1);
        check("alarm_rem", 32'(remaining), 32'd4);
        for (int k = 0; k < 3; k++) tick_pulse();
        check("alarm_rem1", 32'(remaining), 32'd1);
        tick_pulse();
        check("alarm_end_state", 32'(state), 32'd2);
        check("alarm_end_siren", 32'(siren), 32'd0);
        check("alarm_end_mem", 32'(alarm_mem), 32'd1);

        zone = 4'b0100; disarm = 1'b1;
        step(1);
        check("disarm_beats_zone", 32'(state), 32'd0);
        check("disarm_clears_mem", 32'(alarm_mem), 32'd0);
        zone = 4'b0000; disarm = 1'b0; arm = 1'b1;
        step(1);
        arm = 1'b0;
        for (int k = 0; k < 3; k++) tick_pulse();
        check("rearmed", 32'(state), 32'd2);
        zone = 4'b0100;
        step(1);
        check("instant_alarm", 32'(state), 32'd4);
        check("instant_siren", 32'(siren), 32'd1);
        zone = 4'b0000;
        step(3);

        Mr = 1'b0;
        step(1);
        check("mr_alarm_state", 32'(state), 32'd0);
        check("mr_alarm_out", {29'd0, siren, alarm_mem, 1'b0}, 32'd0);
        check("mr_alarm_rem", 32'(remaining), 32'd0);
        step(1);
        Mr = 1'b1;

        arm = 1'b1; disarm = 1'b1;
        step(1);
        check("arm_disarm_stay", 32'(state), 32'd0);
        disarm = 1'b0;
        step(1);
        check("arm_after", 32'(state), 32'd1);
        arm = 1'b0; zone = 4'b0001;
        for (int k = 0; k < 3; k++) tick_pulse();
        check("exit_to_entry", 32'(state), 32'd3);
        check("exit_to_entry_rem", 32'(remaining), 32'd2);
        zone = 4'b0000; disarm = 1'b1;
        step(1);
        check("entry_disarm", 32'(state), 32'd0);
        disarm = 1'b0;

        arm = 1'b1;
        step(1);
        arm = 1'b0; tick = 1'b1;
        step(1);
        check("entry_cycle_tick_ignored", 32'(remaining), 32'd3);
        tick = 1'b0;
        step(2);
        tick = 1'b1;
        step(40);
        check("held_tick_once", 32'(remaining), 32'd2);
        tick = 1'b0;
        step(1);
        check("held_tick_after", 32'(remaining), 32'd2);
        disarm = 1'b1;
        step(1);
        disarm = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            tick   = ($urandom_range(0, 3) == 0);
            arm    = ($urandom_range(0, 7) == 0);
            disarm = ($urandom_range(0, 39) == 0);
            Mr     = ($urandom_range(0, 299) != 0);
            zone   = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
